// File: rtl/lcd_char_writer_if.sv
// ---------------------------------------------------------------------------
// lcd_char_writer_if
// Bundles the front-end inputs (switch character plus four debounced button
// levels) and the HD44780 parallel bus and status outputs of lcd_char_writer.
//   char_in      8  ASCII character from the switches
//   next_letter  1  level, rising edge writes char_in
//   next_word    1  level, rising edge writes a space
//   clear        1  level, rising edge clears display and unlocks
//   done         1  level, rising edge locks entry
//   lcd_rs       1  0 = command, 1 = data
//   lcd_e        1  LCD enable strobe
//   lcd_d        8  LCD data bus
//   busy         1  init or write in progress
//   col          4  next cursor column
//   line         1  next cursor line
//   locked       1  entry locked since last clear
// master: the front end / bench side. slave: the writer.
// ---------------------------------------------------------------------------
interface lcd_char_writer_if;
  logic [7:0] char_in;
  logic       next_letter;
  logic       next_word;
  logic       clear;
  logic       done;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_d;
  logic       busy;
  logic [3:0] col;
  logic       line;
  logic       locked;

  modport master (
    output char_in, next_letter, next_word, clear, done,
    input  lcd_rs, lcd_e, lcd_d, busy, col, line, locked
  );

  modport slave (
    input  char_in, next_letter, next_word, clear, done,
    output lcd_rs, lcd_e, lcd_d, busy, col, line, locked
  );
endinterface

// File: rtl/lcd_char_writer.sv
// ---------------------------------------------------------------------------
// lcd_char_writer
// Drives an HD44780-compatible 16x2 LCD over an 8-bit parallel bus. After
// reset it waits T_PWR cycles, then issues the init commands 0x38, 0x0C,
// 0x01, 0x06. In IDLE it turns rising edges of the four button levels into
// data writes (letter / space), a clear command, or an entry lock, and keeps
// the cursor position, issuing a DDRAM address command when a line fills.
//
// Every bus write is SETUP (1 cycle, rs/d driven), PULSE (E_CYC cycles,
// lcd_e high), HOLD (1 cycle), WAIT (T_CMD, or T_CLR for command 0x01).
// INIT and WRAP act as the SETUP cycle for init and address commands.
//
// Ports:
//   sysclk  in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   bus     slave modport of lcd_char_writer_if (see interface header)
// ---------------------------------------------------------------------------
module lcd_char_writer #(
  parameter int E_CYC = 12,
  parameter int T_CMD = 600,
  parameter int T_CLR = 24000,
  parameter int T_PWR = 240000
) (
  input  logic               sysclk,
  input  logic               rst,
  lcd_char_writer_if.slave   bus
);

  localparam int MAX_A = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int MAX_B = (T_CMD > E_CYC) ? T_CMD : E_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_WRAP
  } state_t;

  // What the write currently on the bus is for; decides where WAIT exits to.
  typedef enum logic [1:0] {
    K_INIT,
    K_CLR,
    K_DATA,
    K_WRAP
  } kind_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  kind_t              r_kind;
  logic [1:0]         r_init_idx;
  logic               r_rs;
  logic [7:0]         r_d;
  logic [3:0]         r_col;
  logic               r_line;
  logic               r_locked;

  logic               r_prev_nl;
  logic               r_prev_nw;
  logic               r_prev_clr;
  logic               r_prev_done;

  logic               w_edge_nl;
  logic               w_edge_nw;
  logic               w_edge_clr;
  logic               w_edge_done;
  logic               w_idle;
  logic               w_take_clr;
  logic               w_take_done;
  logic               w_take_word;
  logic               w_take_letter;
  logic               w_long_wait;
  logic               w_pwr_last;
  logic               w_pulse_last;
  logic               w_wait_last;
  logic               w_e;
  logic               w_busy;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Edge-detect history loads the live levels even during reset, so a
  // button held through reset never looks like a fresh press.
  always_ff @(posedge sysclk) begin
    r_prev_nl   <= bus.next_letter;
    r_prev_nw   <= bus.next_word;
    r_prev_clr  <= bus.clear;
    r_prev_done <= bus.done;
  end

  assign w_edge_nl   = bus.next_letter & ~r_prev_nl;
  assign w_edge_nw   = bus.next_word   & ~r_prev_nw;
  assign w_edge_clr  = bus.clear       & ~r_prev_clr;
  assign w_edge_done = bus.done        & ~r_prev_done;

  // Priority clear > done > next_word > next_letter; only one event per cycle.
  assign w_idle        = (r_state == S_IDLE);
  assign w_take_clr    = w_idle & w_edge_clr;
  assign w_take_done   = w_idle & ~w_edge_clr & w_edge_done;
  assign w_take_word   = w_idle & ~w_edge_clr & ~w_edge_done & w_edge_nw & ~r_locked;
  assign w_take_letter = w_idle & ~w_edge_clr & ~w_edge_done & ~w_edge_nw
                         & w_edge_nl & ~r_locked;

  // Clear-display command needs the long settle time wherever it comes from.
  assign w_long_wait  = ~r_rs & (r_d == 8'h01);
  assign w_pwr_last   = (r_cnt == CNT_W'(T_PWR - 1));
  assign w_pulse_last = (r_cnt == CNT_W'(E_CYC - 1));
  assign w_wait_last  = w_long_wait ? (r_cnt == CNT_W'(T_CLR - 1))
                                    : (r_cnt == CNT_W'(T_CMD - 1));

  // State register
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= S_PWR_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PWR_WAIT: if (w_pwr_last) w_next = S_INIT;
      S_INIT:     w_next = S_PULSE;
      S_IDLE:     if (w_take_clr | w_take_word | w_take_letter) w_next = S_SETUP;
      S_SETUP:    w_next = S_PULSE;
      S_WRAP:     w_next = S_PULSE;
      S_PULSE:    if (w_pulse_last) w_next = S_HOLD;
      S_HOLD:     w_next = S_WAIT;
      S_WAIT: begin
        if (w_wait_last) begin
          case (r_kind)
            K_INIT:  w_next = (r_init_idx == 2'd3) ? S_IDLE : S_INIT;
            K_DATA:  w_next = (r_col == 4'd15) ? S_WRAP : S_IDLE;
            default: w_next = S_IDLE;
          endcase
        end
      end
      default:    w_next = S_PWR_WAIT;
    endcase
  end

  // Output logic
  always_comb begin
    w_e    = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      S_PULSE: w_e    = 1'b1;
      S_IDLE:  w_busy = 1'b0;
      default: begin
        w_e    = 1'b0;
        w_busy = 1'b1;
      end
    endcase
  end

  // Timer, bus registers and cursor tracking
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_kind     <= K_INIT;
      r_init_idx <= 2'd0;
      r_rs       <= 1'b0;
      r_d        <= 8'h00;
      r_col      <= 4'd0;
      r_line     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      // Each timed state starts counting from zero on entry.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == S_PWR_WAIT && w_next == S_INIT) begin
        r_rs       <= 1'b0;
        r_d        <= init_cmd(2'd0);
        r_kind     <= K_INIT;
        r_init_idx <= 2'd0;
      end

      if (r_state == S_WAIT && w_next == S_INIT) begin
        r_d        <= init_cmd(r_init_idx + 2'd1);
        r_init_idx <= r_init_idx + 2'd1;
      end

      if (w_take_clr) begin
        r_rs     <= 1'b0;
        r_d      <= 8'h01;
        r_kind   <= K_CLR;
        r_locked <= 1'b0;
      end

      if (w_take_done) begin
        r_locked <= 1'b1;
      end

      if (w_take_word) begin
        r_rs   <= 1'b1;
        r_d    <= 8'h20;
        r_kind <= K_DATA;
      end

      // char_in is sampled only here, so later switch moves cannot leak
      // into the write already on the bus.
      if (w_take_letter) begin
        r_rs   <= 1'b1;
        r_d    <= bus.char_in;
        r_kind <= K_DATA;
      end

      // Column 15 just written: move the DDRAM address to the other line.
      if (r_state == S_WAIT && w_next == S_WRAP) begin
        r_rs   <= 1'b0;
        r_d    <= r_line ? 8'h80 : 8'hC0;
        r_kind <= K_WRAP;
      end

      // Cursor only moves once the whole write (including any wrap) is done.
      if (r_state == S_WAIT && w_next == S_IDLE) begin
        case (r_kind)
          K_DATA: r_col <= r_col + 4'd1;
          K_WRAP: begin
            r_col  <= 4'd0;
            r_line <= ~r_line;
          end
          default: begin
            r_col  <= 4'd0;
            r_line <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lcd_rs = r_rs;
  assign bus.lcd_e  = w_e;
  assign bus.lcd_d  = r_d;
  assign bus.busy   = w_busy;
  assign bus.col    = r_col;
  assign bus.line   = r_line;
  assign bus.locked = r_locked;

endmodule

// File: tb/tb_lcd_char_writer.sv
module tb_lcd_char_writer;
  localparam int E_CYC = 2;
  localparam int T_CMD = 4;
  localparam int T_CLR = 8;
  localparam int T_PWR = 10;

  localparam int INIT_CYC   = T_PWR + 3 * (2 + E_CYC + T_CMD) + (2 + E_CYC + T_CLR);
  localparam int LETTER_CYC = 3 + E_CYC + T_CMD;
  localparam int CLEAR_CYC  = 3 + E_CYC + T_CLR;
  localparam int WRAP_CYC   = LETTER_CYC + 2 + E_CYC + T_CMD;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  lcd_char_writer_if bus ();

  lcd_char_writer #(
    .E_CYC(E_CYC),
    .T_CMD(T_CMD),
    .T_CLR(T_CLR),
    .T_PWR(T_PWR)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every rising lcd_e is one bus write; pop and compare {rs,d}.
  logic       prev_e   = 1'b0;
  bit         in_pulse = 1'b0;
  int         e_len    = 0;
  logic [8:0] rise_val;
  logic [8:0] exp_v;

  always @(negedge sysclk) begin
    if (bus.lcd_e && !prev_e) begin
      rise_val = {bus.lcd_rs, bus.lcd_d};
      in_pulse = 1'b1;
      e_len    = 1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write", rise_val);
      end else begin
        exp_v = exp_q.pop_front();
        check("bus_write", int'(rise_val), int'(exp_v));
      end
    end else if (bus.lcd_e && in_pulse) begin
      e_len++;
    end else if (!bus.lcd_e && prev_e && in_pulse) begin
      check("e_width", e_len, E_CYC);
      check("hold_stable", int'({bus.lcd_rs, bus.lcd_d}), int'(rise_val));
      in_pulse = 1'b0;
    end
    if (rst) in_pulse = 1'b0;
    prev_e = bus.lcd_e;
  end

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // Button levels must already be raised; the next edge is the capture cycle.
  task automatic run_event(input string name, input int exp_cycles, input logic [7:0] char_after);
    int n;
    tick();
    n = 1;
    bus.next_letter = 1'b0;
    bus.next_word   = 1'b0;
    bus.clear       = 1'b0;
    bus.done        = 1'b0;
    bus.char_in     = char_after;
    while (bus.busy && n < 300) begin
      tick();
      n++;
    end
    check(name, n, exp_cycles);
    tick();
  endtask

  // Called with rst high and already sampled; drops rst and times init.
  task automatic do_init(input string name);
    int n;
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.busy && n < 1000);
    check(name, n, INIT_CYC);
    check("init_col", int'(bus.col), 0);
    check("init_line", int'(bus.line), 0);
    check("init_locked", int'(bus.locked), 0);
  endtask

  task automatic letter(input string name, input logic [7:0] ch, input int exp_cycles);
    bus.char_in = ch;
    exp_q.push_back({1'b1, ch});
    bus.next_letter = 1'b1;
    run_event(name, exp_cycles, ch);
  endtask

  initial begin
    int n;
    logic [7:0] ch;
    bus.char_in     = 8'h00;
    bus.next_letter = 1'b0;
    bus.next_word   = 1'b0;
    bus.clear       = 1'b0;
    bus.done        = 1'b0;
    rst = 1'b1;
    repeat (3) tick();

    check("rst_rs", int'(bus.lcd_rs), 0);
    check("rst_e", int'(bus.lcd_e), 0);
    check("rst_d", int'(bus.lcd_d), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_col", int'(bus.col), 0);
    check("rst_line", int'(bus.line), 0);
    check("rst_locked", int'(bus.locked), 0);

    do_init("init_busy_fall");

    // Single letter; switch changes to 0x42 during the write.
    bus.char_in = 8'h41;
    exp_q.push_back(9'h141);
    bus.next_letter = 1'b1;
    run_event("letter_busy", LETTER_CYC, 8'h42);
    check("letter_col", int'(bus.col), 1);

    // Fill line 0 (15 more letters), last one wraps to line 1.
    for (int i = 0; i < 15; i++) begin
      ch = 8'h61 + 8'(i);
      if (i == 14) begin
        bus.char_in = ch;
        exp_q.push_back({1'b1, ch});
        exp_q.push_back(9'h0C0);
        bus.next_letter = 1'b1;
        run_event("wrap1_busy", WRAP_CYC, ch);
      end else begin
        letter("fill0_busy", ch, LETTER_CYC);
      end
    end
    check("wrap1_line", int'(bus.line), 1);
    check("wrap1_col", int'(bus.col), 0);

    for (int i = 0; i < 16; i++) begin
      ch = 8'h30 + 8'(i);
      if (i == 15) begin
        bus.char_in = ch;
        exp_q.push_back({1'b1, ch});
        exp_q.push_back(9'h080);
        bus.next_letter = 1'b1;
        run_event("wrap0_busy", WRAP_CYC, ch);
      end else begin
        letter("fill1_busy", ch, LETTER_CYC);
      end
    end
    check("wrap0_line", int'(bus.line), 0);
    check("wrap0_col", int'(bus.col), 0);

    // Priority and lock.
    letter("pre_clr_letter", 8'h5A, LETTER_CYC);
    check("pre_clr_col", int'(bus.col), 1);
    exp_q.push_back(9'h001);
    bus.char_in     = 8'h51;
    bus.clear       = 1'b1;
    bus.next_letter = 1'b1;
    run_event("clr_prio_busy", CLEAR_CYC, 8'h51);
    check("clr_prio_col", int'(bus.col), 0);
    check("clr_prio_locked", int'(bus.locked), 0);

    bus.done = 1'b1;
    run_event("done_busy", 1, 8'h51);
    check("done_locked", int'(bus.locked), 1);

    bus.next_letter = 1'b1;
    run_event("locked_letter", 1, 8'h51);
    bus.next_word = 1'b1;
    run_event("locked_word", 1, 8'h51);
    repeat (5) tick();
    check("locked_idle_busy", int'(bus.busy), 0);
    check("locked_col", int'(bus.col), 0);

    exp_q.push_back(9'h001);
    bus.clear = 1'b1;
    run_event("unlock_clr_busy", CLEAR_CYC, 8'h51);
    check("unlock_locked", int'(bus.locked), 0);
    check("unlock_col", int'(bus.col), 0);

    // Space write; a next_letter edge during WAIT must be dropped.
    exp_q.push_back(9'h120);
    bus.next_word = 1'b1;
    tick();
    bus.next_word = 1'b0;
    n = 1;
    while (bus.busy && n < 300) begin
      tick();
      n++;
      if (n == 6) bus.next_letter = 1'b1;
    end
    check("word_busy", n, LETTER_CYC);
    check("word_col", int'(bus.col), 1);
    bus.next_letter = 1'b0;
    repeat (12) tick();
    check("dropped_edge_busy", int'(bus.busy), 0);
    check("dropped_edge_col", int'(bus.col), 1);

    // Reset while lcd_e is high.
    bus.char_in = 8'h4D;
    exp_q.push_back(9'h14D);
    bus.next_letter = 1'b1;
    tick();
    bus.next_letter = 1'b0;
    tick();
    tick();
    check("pre_rst_e", int'(bus.lcd_e), 1);
    rst = 1'b1;
    tick();
    check("midrst_e", int'(bus.lcd_e), 0);
    check("midrst_busy", int'(bus.busy), 1);
    check("midrst_col", int'(bus.col), 0);
    check("midrst_rs", int'(bus.lcd_rs), 0);
    do_init("reinit_busy_fall");

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
